// File: rtl/cpu_pkg.sv
// Shared fetch/redirect encoding: PC defaults and redirect source indices
// used by the PC unit and by every stage that issues redirects.
package cpu_pkg;

  localparam int unsigned PC_WIDTH   = 32'd32;
  localparam int unsigned PC_NUM_SRC = 32'd3;
  localparam logic [31:0] PC_RESET   = 32'h0000_0000;
  localparam int unsigned PC_INC     = 32'd4;

  // Lower index means higher priority.
  localparam int unsigned SRC_EXC    = 32'd0;
  localparam int unsigned SRC_BRANCH = 32'd1;
  localparam int unsigned SRC_JUMP   = 32'd2;

  function automatic int unsigned src_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Redirect request / fetch PC bundle between the issuing stages and the
// PC redirect unit.
interface pc_redirect_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH   = PC_WIDTH,
  parameter int unsigned NUM_SRC = PC_NUM_SRC
);
  localparam int unsigned SRC_W = src_width(NUM_SRC);

  logic                     stall;
  logic [NUM_SRC-1:0]       redirect_valid;
  logic [NUM_SRC*WIDTH-1:0] redirect_addr;
  logic [WIDTH-1:0]         pc;
  logic [WIDTH-1:0]         pc_plus_inc;
  logic                     flush;
  logic [SRC_W-1:0]         flush_src;
  logic                     pending;

  modport master (
    output stall, redirect_valid, redirect_addr,
    input  pc, pc_plus_inc, flush, flush_src, pending
  );

  modport slave (
    input  stall, redirect_valid, redirect_addr,
    output pc, pc_plus_inc, flush, flush_src, pending
  );

endinterface

// File: rtl/redirect_prio_sel.sv
// Combinational priority pick between the live redirect requests and the
// single buffered (pending) redirect; the chosen target is already aligned.
module redirect_prio_sel
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH   = PC_WIDTH,
  parameter int unsigned NUM_SRC = PC_NUM_SRC,
  parameter int unsigned INC     = PC_INC,
  localparam int unsigned SRC_W  = src_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]       valid,
  input  logic [NUM_SRC*WIDTH-1:0] addr,
  input  logic                     pend_valid,
  input  logic [SRC_W-1:0]         pend_src,
  input  logic [WIDTH-1:0]         pend_addr,
  output logic                     cand_valid,
  output logic [SRC_W-1:0]         cand_src,
  output logic [WIDTH-1:0]         cand_addr
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(INC) - WIDTH'(1));

  logic             live_valid_s;
  logic [SRC_W-1:0] live_src_s;
  logic [WIDTH-1:0] live_addr_s;

  // Live winner: scanning from the lowest priority up lets index 0 overwrite last.
  always_comb begin
    live_valid_s = 1'b0;
    live_src_s   = '0;
    live_addr_s  = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (valid[i]) begin
        live_valid_s = 1'b1;
        live_src_s   = SRC_W'(i);
        live_addr_s  = addr[i*WIDTH +: WIDTH] & ALIGN_MASK;
      end else begin
        live_valid_s = live_valid_s;
      end
    end
  end

  // A live request of equal or higher priority replaces the pending one.
  always_comb begin
    cand_valid = 1'b0;
    cand_src   = '0;
    cand_addr  = '0;
    if (live_valid_s && (!pend_valid || (live_src_s <= pend_src))) begin
      cand_valid = 1'b1;
      cand_src   = live_src_s;
      cand_addr  = live_addr_s;
    end else if (pend_valid) begin
      cand_valid = 1'b1;
      cand_src   = pend_src;
      cand_addr  = pend_addr;
    end else begin
      cand_valid = 1'b0;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register: sequential increment or prioritised redirect, with a
// one-entry buffer that keeps the winning redirect alive across stalls.
module pc_redirect_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH    = PC_WIDTH,
  parameter int unsigned      NUM_SRC  = PC_NUM_SRC,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET),
  parameter int unsigned      INC      = PC_INC
) (
  input logic              clk,
  input logic              rst_n,
  pc_redirect_unit_if.slave bus
);

  localparam int unsigned SRC_W = src_width(NUM_SRC);

  logic [WIDTH-1:0] pc_r;
  logic             flush_r;
  logic [SRC_W-1:0] flush_src_r;
  logic             pend_valid_r;
  logic [SRC_W-1:0] pend_src_r;
  logic [WIDTH-1:0] pend_addr_r;

  logic             cand_valid_s;
  logic [SRC_W-1:0] cand_src_s;
  logic [WIDTH-1:0] cand_addr_s;

  redirect_prio_sel #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .INC     (INC)
  ) u_prio_sel (
    .valid      (bus.redirect_valid),
    .addr       (bus.redirect_addr),
    .pend_valid (pend_valid_r),
    .pend_src   (pend_src_r),
    .pend_addr  (pend_addr_r),
    .cand_valid (cand_valid_s),
    .cand_src   (cand_src_s),
    .cand_addr  (cand_addr_s)
  );

  // PC, flush pulse and the single pending redirect slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_PC;
      flush_r      <= 1'b0;
      flush_src_r  <= '0;
      pend_valid_r <= 1'b0;
      pend_src_r   <= '0;
      pend_addr_r  <= '0;
    end else if (!bus.stall) begin
      if (cand_valid_s) begin
        pc_r         <= cand_addr_s;
        flush_r      <= 1'b1;
        flush_src_r  <= cand_src_s;
        pend_valid_r <= 1'b0;
      end else begin
        pc_r    <= pc_r + WIDTH'(INC);
        flush_r <= 1'b0;
      end
    end else begin
      // Stalled: PC holds; the best redirect so far is parked for release.
      flush_r <= 1'b0;
      if (cand_valid_s) begin
        pend_valid_r <= 1'b1;
        pend_src_r   <= cand_src_s;
        pend_addr_r  <= cand_addr_s;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  assign bus.pc          = pc_r;
  assign bus.pc_plus_inc = pc_r + WIDTH'(INC);
  assign bus.flush       = flush_r;
  assign bus.flush_src   = flush_src_r;
  assign bus.pending     = pend_valid_r;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed vector bench for pc_redirect_unit (WIDTH=32, NUM_SRC=3, INC=4).
module tb_pc_redirect_unit;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  pc_redirect_unit_if #(.WIDTH(32), .NUM_SRC(3)) bus ();

  pc_redirect_unit #(
    .WIDTH    (32),
    .NUM_SRC  (3),
    .RESET_PC (32'h0000_0000),
    .INC      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [2:0]  valid;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] pc;
    logic        flush;
    logic [1:0]  src;
    logic        pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [2:0] v,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] pc,
                              input logic fl, input logic [1:0] src,
                              input logic pend);
    vec_t r;
    r.stall = st; r.valid = v; r.a0 = a0; r.a1 = a1; r.a2 = a2;
    r.pc = pc; r.flush = fl; r.src = src; r.pend = pend;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic fl,
                           input logic [1:0] src, input logic pend);
    check({tag, ".pc"}, bus.pc, pc);
    check({tag, ".pc_plus_inc"}, bus.pc_plus_inc, pc + 32'd4);
    check({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, fl});
    check({tag, ".flush_src"}, {30'd0, bus.flush_src}, {30'd0, src});
    check({tag, ".pending"}, {31'd0, bus.pending}, {31'd0, pend});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //                st    valid   a0            a1            a2            pc            fl    src    pend
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0008, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_000C, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0010, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b110, 32'h0,        32'h200,      32'h300,      32'h0000_0200, 1'b1, 2'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0204, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(1'b1, 3'b100, 32'h0,        32'h0,        32'h400,      32'h0000_0204, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0204, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 3'b001, 32'h800,      32'h0,        32'h0,        32'h0000_0204, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0800, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0804, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h800,      32'h0,        32'h0,        32'h0000_0804, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 3'b100, 32'h0,        32'h0,        32'h900,      32'h0000_0804, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0800, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0,        32'h600,      32'h0,        32'h0000_0800, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0,        32'h700,      32'h0,        32'h0000_0800, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0700, 1'b1, 2'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'b100, 32'h0,        32'h0,        32'h300,      32'h0000_0300, 1'b1, 2'd2, 1'b0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h40,       32'h0,        32'h0,        32'h0000_0040, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0044, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0,        32'h203,      32'h0,        32'h0000_0200, 1'b1, 2'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0204, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'b001, 32'hFFFF_FFF8, 32'h0,       32'h0,        32'hFFFF_FFF8, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 1'b0, 2'd0, 1'b0));

    rst_n              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 3'b000;
    bus.redirect_addr  = 96'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 32'h0000_0000, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.stall          = vecs[i].stall;
      bus.redirect_valid = vecs[i].valid;
      bus.redirect_addr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].flush, vecs[i].src, vecs[i].pend);
    end

    // Reset asserted mid-cycle while a redirect is parked.
    bus.stall          = 1'b0;
    bus.redirect_valid = 3'b000;
    bus.redirect_addr  = 96'd0;
    @(posedge clk);
    #1;
    check_all("rst_pre", 32'h0000_0004, 1'b0, 2'd0, 1'b0);
    bus.stall          = 1'b1;
    bus.redirect_valid = 3'b010;
    bus.redirect_addr  = {32'h0, 32'h500, 32'h0};
    @(posedge clk);
    #1;
    check_all("rst_park", 32'h0000_0004, 1'b0, 2'd0, 1'b1);
    bus.redirect_valid = 3'b000;
    bus.redirect_addr  = 96'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 32'h0000_0000, 1'b0, 2'd0, 1'b0);
    #2;
    rst_n     = 1'b1;
    bus.stall = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_post", 32'h0000_0004, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_post2", 32'h0000_0008, 1'b0, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
